// File: rtl/case_mul_pipe_hs_if.sv
// case_mul_pipe_hs_if: operand/result handshake bundle for the pipelined multiplier
interface case_mul_pipe_hs_if #(
  parameter int W0 = 9,
  parameter int W1 = 8,
  parameter int WO = 9
);
  logic          in_vld;
  logic          in_rdy;
  logic [W0-1:0] din0;
  logic [W1-1:0] din1;
  logic          out_vld;
  logic          out_rdy;
  logic [WO-1:0] dout;
  logic          ovf;
  modport master (output in_vld, din0, din1, out_rdy, input in_rdy, out_vld, dout, ovf);
  modport slave (input in_vld, din0, din1, out_rdy, output in_rdy, out_vld, dout, ovf);
endinterface

// File: rtl/case_mul_pipe_hs.sv
// case_mul_pipe_hs: pipelined signed/unsigned multiplier with handshake, ce and wrap/saturate narrowing
module case_mul_pipe_hs #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 9,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 9,
  parameter int SIGNED     = 1,
  parameter int SAT_MODE   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic ovf_clr,
  output logic ovf_sticky,
  case_mul_pipe_hs_if.slave bus
);
  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int EW = dout_WIDTH > PW ? dout_WIDTH : PW;
  localparam bit S = SIGNED != 0;
  localparam logic [EW-1:0] HI = {EW{1'b1}} << PW;
  localparam logic [EW-1:0] ONES_HI = {EW{1'b1}} >> (dout_WIDTH - 1);
  localparam logic [dout_WIDTH-1:0] SMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] SMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  if (ID < 0 || NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_param
    $error("case_mul_pipe_hs: NUM_STAGE must be 1..8");
  end

  logic                  stall, adv, acc, last_v, fits;
  logic [PW-1:0]         prod, last_p;
  logic [EW-1:0]         pe;
  logic [dout_WIDTH-1:0] nar;

  assign stall = bus.out_vld & ~bus.out_rdy;
  assign adv = ce & ~stall;
  assign bus.in_rdy = ce & ~reset & ~stall;
  assign acc = bus.in_vld & bus.in_rdy;
  // extending both operands to the full product width makes one unsigned multiply serve both modes
  assign prod = {{din1_WIDTH{S & bus.din0[din0_WIDTH-1]}}, bus.din0}
              * {{din0_WIDTH{S & bus.din1[din1_WIDTH-1]}}, bus.din1};

  if (NUM_STAGE == 1) begin : g_one
    assign last_p = prod;
    assign last_v = acc;
  end else begin : g_pipe
    logic [PW-1:0]        p [NUM_STAGE-1];
    logic [NUM_STAGE-2:0] pv;
    always_ff @(posedge clk) begin
      if (reset) pv <= '0;
      else if (adv) begin
        pv[0] <= acc;
        p[0] <= prod;
        for (int i = 1; i < NUM_STAGE - 1; i++) begin
          pv[i] <= pv[i-1];
          p[i] <= p[i-1];
        end
      end
    end
    assign last_p = p[NUM_STAGE-2];
    assign last_v = pv[NUM_STAGE-2];
  end

  // representable iff every bit above the result's sign position (or above its msb when unsigned) is redundant
  always_comb begin
    pe = (S & last_p[PW-1] ? HI : '0) | EW'(last_p);
    fits = S ? ((pe >> (dout_WIDTH - 1)) == '0 || (pe >> (dout_WIDTH - 1)) == ONES_HI)
             : (pe >> dout_WIDTH) == '0;
    nar = (!fits && SAT_MODE != 0) ? (S ? (pe[EW-1] ? SMIN : SMAX) : '1) : pe[dout_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_vld <= 1'b0;
      bus.dout <= '0;
      bus.ovf <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (ce) begin
      if (!stall) begin
        bus.out_vld <= last_v;
        if (last_v) bus.dout <= nar;
        bus.ovf <= last_v & ~fits;
      end
      ovf_sticky <= (bus.out_vld & bus.out_rdy & bus.ovf) | (ovf_sticky & ~ovf_clr);
    end
  end
endmodule

// File: tb/tb_case_mul_pipe_hs.sv
// tb_case_mul_pipe_hs: three configurations (signed wrap, signed sat, unsigned sat) driven in lockstep against an arithmetic model
module tb_case_mul_pipe_hs;
  logic       clk = 1'b0, reset, ce, ovf_clr, in_vld, out_rdy;
  logic [8:0] din0;
  logic [7:0] din1;
  logic       in_rdy_a [3];
  logic       out_vld_a [3];
  logic       ovf_a [3];
  logic       sticky_a [3];
  logic [8:0] dout_a [3];
  logic [9:0] exp_q [3][$];
  logic [9:0] got_q [3][$];
  bit         sm [3];
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    case_mul_pipe_hs_if #(.W0(9), .W1(8), .WO(9)) bus ();
    assign bus.in_vld = in_vld;
    assign bus.din0 = din0;
    assign bus.din1 = din1;
    assign bus.out_rdy = out_rdy;
    assign in_rdy_a[g] = bus.in_rdy;
    assign out_vld_a[g] = bus.out_vld;
    assign ovf_a[g] = bus.ovf;
    assign dout_a[g] = bus.dout;
    case_mul_pipe_hs #(.ID(g), .NUM_STAGE(3), .din0_WIDTH(9), .din1_WIDTH(8), .dout_WIDTH(9),
                       .SIGNED(g == 2 ? 0 : 1), .SAT_MODE(g == 0 ? 0 : 1)) dut (
      .clk(clk), .reset(reset), .ce(ce), .ovf_clr(ovf_clr), .ovf_sticky(sticky_a[g]), .bus(bus.slave));
  end

  // expected {ovf, dout} from integer arithmetic on the operand values
  function automatic logic [9:0] model(int k, logic [8:0] a, logic [7:0] b);
    bit sg = (k != 2);
    bit sat = (k != 0);
    longint av = sg ? longint'($signed(a)) : longint'(a);
    longint bv = sg ? longint'($signed(b)) : longint'(b);
    longint p = av * bv;
    longint lo = sg ? -256 : 0;
    longint hi = sg ? 255 : 511;
    bit o = (p < lo) || (p > hi);
    longint r = (o && sat) ? (p < lo ? lo : hi) : p;
    return {o, r[8:0]};
  endfunction

  // one clock: record transfers happening at the coming edge, then return to the falling edge
  task automatic step();
    logic [9:0] e;
    bit setb;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        sm[k] = 1'b0;
        while (exp_q[k].size() > got_q[k].size()) void'(exp_q[k].pop_back());
      end else if (ce) begin
        setb = 1'b0;
        if (in_vld && in_rdy_a[k]) exp_q[k].push_back(model(k, din0, din1));
        if (out_vld_a[k] && out_rdy) begin
          got_q[k].push_back({ovf_a[k], dout_a[k]});
          if (exp_q[k].size() >= got_q[k].size()) begin
            e = exp_q[k][got_q[k].size() - 1];
            setb = e[9];
          end
        end
        sm[k] = setb ? 1'b1 : (ovf_clr ? 1'b0 : sm[k]);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_q();
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      got_q[k].delete();
    end
  endtask

  task automatic drain();
    in_vld = 1'b0;
    out_rdy = 1'b1;
    ce = 1'b1;
    ovf_clr = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      checks += 4;
      if (out_vld_a[k] !== 1'b0) begin errors++; $display("FAIL reset_out_vld[%0d] got %b exp 0", k, out_vld_a[k]); end
      if (dout_a[k] !== 9'd0) begin errors++; $display("FAIL reset_dout[%0d] got %h exp 0", k, dout_a[k]); end
      if (ovf_a[k] !== 1'b0 || sticky_a[k] !== 1'b0) begin errors++; $display("FAIL reset_ovf[%0d] got %b/%b exp 0/0", k, ovf_a[k], sticky_a[k]); end
      if (in_rdy_a[k] !== 1'b0) begin errors++; $display("FAIL reset_in_rdy[%0d] got %b exp 0", k, in_rdy_a[k]); end
    end
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_rdy_a[k] !== 1'b1) begin errors++; $display("FAIL idle_in_rdy[%0d] got %b exp 1", k, in_rdy_a[k]); end
    end
  endtask

  task automatic test_directed();
    logic [8:0] a [5] = '{9'd10, 9'h100, 9'h100, 9'h1FF, 9'd3};
    logic [7:0] b [5] = '{8'hFD, 8'h80, 8'h7F, 8'hFF, 8'h04};
    clear_q();
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1;
      din0 = a[i];
      din1 = b[i];
      step();
    end
    drain();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_q[k].size() != 5 || exp_q[k].size() != 5) begin
        errors++;
        $display("FAIL dir_count[%0d] got %0d exp 5", k, got_q[k].size());
      end else for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_q[k][i] !== exp_q[k][i]) begin errors++; $display("FAIL dir_result[%0d][%0d] got %h exp %h", k, i, got_q[k][i], exp_q[k][i]); end
      end
      checks++;
      if (sticky_a[k] !== 1'b1) begin errors++; $display("FAIL dir_sticky[%0d] got %b exp 1", k, sticky_a[k]); end
    end
    if (got_q[0].size() == 5 && got_q[1].size() == 5 && got_q[2].size() == 5) begin
      checks += 6;
      if (got_q[0][0] !== {1'b0, 9'h1E2}) begin errors++; $display("FAIL wrap_neg30 got %h exp 1e2", got_q[0][0]); end
      if (got_q[0][1] !== {1'b1, 9'h000}) begin errors++; $display("FAIL wrap_ovf got %h exp 200", got_q[0][1]); end
      if (got_q[1][1] !== {1'b1, 9'd255}) begin errors++; $display("FAIL sat_pos got %h exp 2ff", got_q[1][1]); end
      if (got_q[1][2] !== {1'b1, 9'h100}) begin errors++; $display("FAIL sat_neg got %h exp 300", got_q[1][2]); end
      if (got_q[2][3] !== {1'b1, 9'd511}) begin errors++; $display("FAIL usat_max got %h exp 3ff", got_q[2][3]); end
      if (got_q[2][4] !== {1'b0, 9'd12}) begin errors++; $display("FAIL usat_small got %h exp 00c", got_q[2][4]); end
    end
  endtask

  task automatic test_latency();
    int lat;
    in_vld = 1'b1;
    din0 = 9'd5;
    din1 = 8'd7;
    step();
    in_vld = 1'b0;
    lat = 1;
    while (!out_vld_a[0] && lat < 10) begin
      step();
      lat++;
    end
    checks += 2;
    if (lat != 3) begin errors++; $display("FAIL latency got %0d exp 3", lat); end
    if (dout_a[0] !== 9'd35) begin errors++; $display("FAIL latency_dout got %0d exp 35", dout_a[0]); end
    drain();
  endtask

  task automatic test_sticky();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sticky_a[k] !== 1'b0) begin errors++; $display("FAIL sticky_clr[%0d] got %b exp 0", k, sticky_a[k]); end
    end
    in_vld = 1'b1;
    din0 = 9'h100;
    din1 = 8'h80;
    step();
    in_vld = 1'b0;
    ovf_clr = 1'b1;
    repeat (2) step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_vld_a[k] !== 1'b1 || ovf_a[k] !== 1'b1) begin errors++; $display("FAIL sticky_pend[%0d] got %b/%b exp 1/1", k, out_vld_a[k], ovf_a[k]); end
    end
    step();
    ovf_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sticky_a[k] !== 1'b1 || sm[k] !== 1'b1) begin errors++; $display("FAIL sticky_set_wins[%0d] got %b exp 1", k, sticky_a[k]); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [8:0] a [8];
    logic [7:0] b [8];
    logic [8:0] hold [3];
    int idx = 0;
    clear_q();
    for (int i = 0; i < 8; i++) begin
      a[i] = 9'($urandom);
      b[i] = 8'($urandom);
    end
    for (int c = 0; c < 30; c++) begin
      in_vld = idx < 8;
      din0 = a[idx < 8 ? idx : 0];
      din1 = b[idx < 8 ? idx : 0];
      out_rdy = !(c >= 4 && c <= 6);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (c >= 4 && c <= 6) begin
          checks += 2;
          if (in_rdy_a[k] !== 1'b0 || out_vld_a[k] !== 1'b1) begin errors++; $display("FAIL stall_rdy[%0d] c%0d got in_rdy %b out_vld %b exp 0/1", k, c, in_rdy_a[k], out_vld_a[k]); end
          if (c == 4) hold[k] = dout_a[k];
          if (dout_a[k] !== hold[k]) begin errors++; $display("FAIL stall_stable[%0d] c%0d got %h exp %h", k, c, dout_a[k], hold[k]); end
        end
      end
      if (in_vld && in_rdy_a[0]) idx++;
      step();
    end
    drain();
    checks++;
    if (idx != 8) begin errors++; $display("FAIL b2b_accepted got %0d exp 8", idx); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_q[k].size() != 8 || exp_q[k].size() != 8) begin
        errors++;
        $display("FAIL b2b_count[%0d] got %0d exp 8", k, got_q[k].size());
      end else for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[k][i] !== exp_q[k][i]) begin errors++; $display("FAIL b2b_result[%0d][%0d] got %h exp %h", k, i, got_q[k][i], exp_q[k][i]); end
      end
    end
  endtask

  task automatic test_ce();
    logic [8:0] hold [3];
    clear_q();
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1;
      din0 = 9'($urandom);
      din1 = 8'($urandom);
      step();
    end
    in_vld = 1'b1;
    ce = 1'b0;
    for (int k = 0; k < 3; k++) hold[k] = dout_a[k];
    repeat (3) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (in_rdy_a[k] !== 1'b0 || out_vld_a[k] !== 1'b1 || dout_a[k] !== hold[k]) begin
          errors++;
          $display("FAIL ce_freeze[%0d] got rdy %b vld %b dout %h exp 0 1 %h", k, in_rdy_a[k], out_vld_a[k], dout_a[k], hold[k]);
        end
      end
      step();
    end
    drain();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_q[k].size() != 3 || exp_q[k].size() != 3) begin
        errors++;
        $display("FAIL ce_count[%0d] got %0d exp 3", k, got_q[k].size());
      end else for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[k][i] !== exp_q[k][i]) begin errors++; $display("FAIL ce_result[%0d][%0d] got %h exp %h", k, i, got_q[k][i], exp_q[k][i]); end
      end
    end
  endtask

  task automatic test_reset_flight();
    clear_q();
    in_vld = 1'b1;
    din0 = 9'h100;
    din1 = 8'h80;
    step();
    din0 = 9'd7;
    din1 = 8'd9;
    step();
    in_vld = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_vld_a[k] !== 1'b0 || sticky_a[k] !== 1'b0) begin errors++; $display("FAIL flight_reset[%0d] got vld %b sticky %b exp 0/0", k, out_vld_a[k], sticky_a[k]); end
    end
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (out_vld_a[k] !== 1'b0) begin errors++; $display("FAIL flight_stale[%0d] c%0d got %b exp 0", k, c, out_vld_a[k]); end
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_q[k].size() != 0) begin errors++; $display("FAIL flight_count[%0d] got %0d exp 0", k, got_q[k].size()); end
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int c = 0; c < 120; c++) begin
      ce = $urandom_range(0, 7) != 0;
      in_vld = $urandom_range(0, 1) == 1;
      out_rdy = $urandom_range(0, 3) != 0;
      ovf_clr = $urandom_range(0, 7) == 0;
      din0 = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) == 1 ? 9'h100 : 9'h1FF) : 9'($urandom);
      din1 = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) == 1 ? 8'h80 : 8'h7F) : 8'($urandom);
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (sticky_a[k] !== sm[k]) begin errors++; $display("FAIL rand_sticky[%0d] c%0d got %b exp %b", k, c, sticky_a[k], sm[k]); end
      end
    end
    drain();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_q[k].size() != exp_q[k].size()) begin
        errors++;
        $display("FAIL rand_count[%0d] got %0d exp %0d", k, got_q[k].size(), exp_q[k].size());
      end else for (int i = 0; i < got_q[k].size(); i++) begin
        checks++;
        if (got_q[k][i] !== exp_q[k][i]) begin errors++; $display("FAIL rand_result[%0d][%0d] got %h exp %h", k, i, got_q[k][i], exp_q[k][i]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ce = 1'b1;
    ovf_clr = 1'b0;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    din0 = '0;
    din1 = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_latency();
    test_sticky();
    test_back_to_back();
    test_ce();
    test_reset_flight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
